// File: rtl/turf_keys_pkg.sv
// ============================================================================
// Module  : turf_keys_pkg
// Brief   : Key codes, PS/2 scancodes, receiver states and the key map lookup.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package turf_keys_pkg;

  localparam logic [4:0] KEY_P1_UP    = 5'd0;
  localparam logic [4:0] KEY_P1_DOWN  = 5'd1;
  localparam logic [4:0] KEY_P1_LEFT  = 5'd2;
  localparam logic [4:0] KEY_P1_RIGHT = 5'd3;
  localparam logic [4:0] KEY_P2_UP    = 5'd4;
  localparam logic [4:0] KEY_P2_DOWN  = 5'd5;
  localparam logic [4:0] KEY_P2_LEFT  = 5'd6;
  localparam logic [4:0] KEY_P2_RIGHT = 5'd7;
  localparam logic [4:0] KEY_P3_UP    = 5'd8;
  localparam logic [4:0] KEY_P3_DOWN  = 5'd9;
  localparam logic [4:0] KEY_P3_LEFT  = 5'd10;
  localparam logic [4:0] KEY_P3_RIGHT = 5'd11;
  localparam logic [4:0] KEY_P4_UP    = 5'd12;
  localparam logic [4:0] KEY_P4_DOWN  = 5'd13;
  localparam logic [4:0] KEY_P4_LEFT  = 5'd14;
  localparam logic [4:0] KEY_P4_RIGHT = 5'd15;
  localparam logic [4:0] KEY_RESET    = 5'd16;
  localparam logic [4:0] IDLE_CODE    = 5'd31;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [4:0] code;
  } key_map_t;

  // Arrow keys and keypad share scancodes; only the E0 prefix separates P2 from P4.
  function automatic key_map_t map_key(input logic ext, input logic [7:0] sc);
    key_map_t m;
    m.hit  = 1'b1;
    m.code = IDLE_CODE;
    case ({ext, sc})
      {1'b0, SC_W}:     m.code = KEY_P1_UP;
      {1'b0, SC_S}:     m.code = KEY_P1_DOWN;
      {1'b0, SC_A}:     m.code = KEY_P1_LEFT;
      {1'b0, SC_D}:     m.code = KEY_P1_RIGHT;
      {1'b1, SC_UP}:    m.code = KEY_P2_UP;
      {1'b1, SC_DOWN}:  m.code = KEY_P2_DOWN;
      {1'b1, SC_LEFT}:  m.code = KEY_P2_LEFT;
      {1'b1, SC_RIGHT}: m.code = KEY_P2_RIGHT;
      {1'b0, SC_I}:     m.code = KEY_P3_UP;
      {1'b0, SC_K}:     m.code = KEY_P3_DOWN;
      {1'b0, SC_J}:     m.code = KEY_P3_LEFT;
      {1'b0, SC_L}:     m.code = KEY_P3_RIGHT;
      {1'b0, SC_UP}:    m.code = KEY_P4_UP;
      {1'b0, SC_DOWN}:  m.code = KEY_P4_DOWN;
      {1'b0, SC_LEFT}:  m.code = KEY_P4_LEFT;
      {1'b0, SC_RIGHT}: m.code = KEY_P4_RIGHT;
      {1'b0, SC_SPACE}: m.code = KEY_RESET;
      default:          m.hit  = 1'b0;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// Module  : ps2_rx
// Brief   : PS/2 byte receiver: synchronisers, falling-edge detect, frame FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_byte_valid_o,
  output logic       rx_error_o
);
  import turf_keys_pkg::*;

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_valid_q, byte_valid_d;
  logic          error_q, error_d;
  logic          fall, dat;

  assign fall = clk_prev_q & ~clk_sync_q[1];
  assign dat  = dat_sync_q[1];

  // Synchronisers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      clk_prev_q   <= 1'b1;
      state_q      <= RX_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q   <= {dat_sync_q[0], ps2_dat_i};
      clk_prev_q   <= clk_sync_q[1];
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tmo_d        = tmo_q;
    byte_valid_d = 1'b0;
    error_d      = 1'b0;

    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          parity_d = dat;
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          if (dat && ((^shift_q) ^ parity_q)) byte_valid_d = 1'b1;
          else                                error_d      = 1'b1;
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end

    if (state_q == RX_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d   = '0;
      state_d = RX_IDLE;
      error_d = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  assign rx_byte_o       = shift_q;
  assign rx_byte_valid_o = byte_valid_q;
  assign rx_error_o      = error_q;

endmodule

`default_nettype wire

// File: rtl/ps2_key_mapper.sv
// ============================================================================
// Module  : ps2_key_mapper
// Brief   : Decodes PS/2 make/break/extended scancodes into one-cycle key codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_mapper #(
  parameter logic [4:0] IDLE_CODE      = 5'd31,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [4:0] KEY_PRESSED,
  output logic       key_valid,
  output logic       rx_error
);
  import turf_keys_pkg::*;

  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_err;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [4:0] key_q, key_d;
  logic       valid_q, valid_d;
  key_map_t   hit;

  ps2_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i           (CLOCK_50),
    .rst_i           (reset),
    .ps2_clk_i       (PS2_CLK),
    .ps2_dat_i       (PS2_DAT),
    .rx_byte_o       (rx_byte),
    .rx_byte_valid_o (rx_byte_valid),
    .rx_error_o      (rx_err)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      key_q   <= IDLE_CODE;
      valid_q <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end

  assign hit = map_key(ext_q, rx_byte);

  // A corrupted frame may have been half of a prefixed sequence, so prefixes are dropped.
  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    key_d   = IDLE_CODE;
    valid_d = 1'b0;
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_byte_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!brk_q && hit.hit) begin
          key_d   = hit.code;
          valid_d = 1'b1;
        end
      end
    end
  end

  assign KEY_PRESSED = key_q;
  assign key_valid   = valid_q;
  assign rx_error    = rx_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_mapper.sv
// ============================================================================
// Module  : tb_ps2_key_mapper
// Brief   : Self-checking bench: vector table, corner sequences, random frames.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_mapper;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [4:0] KEY_PRESSED;
  logic       key_valid;
  logic       rx_error;

  int checks = 0;
  int errors = 0;

  ps2_key_mapper dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .PS2_CLK     (PS2_CLK),
    .PS2_DAT     (PS2_DAT),
    .KEY_PRESSED (KEY_PRESSED),
    .key_valid   (key_valid),
    .rx_error    (rx_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Observed events
  int ev_codes[$];
  int err_seen  = 0;
  int idle_bad  = 0;
  int multi_bad = 0;
  bit prev_valid = 1'b0;

  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (key_valid) ev_codes.push_back(int'(KEY_PRESSED));
      else if (KEY_PRESSED !== 5'd31) idle_bad++;
      if (key_valid && prev_valid) multi_bad++;
      if (rx_error) err_seen++;
      prev_valid = key_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Reference model: prefix state plus a scancode table indexed by key code
  bit         m_ext, m_brk;
  logic [7:0] sc_tab [17];
  bit         ext_tab[17];

  task automatic model_byte(input logic [7:0] b, input bit ok,
                            output int n, output int code, output int err);
    n = 0; code = 31; err = 0;
    if (!ok) begin
      err = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (!m_brk) begin
        for (int k = 0; k < 17; k++)
          if (sc_tab[k] == b && ext_tab[k] == m_ext) begin
            n = 1; code = k;
          end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic ps2_bit(input bit b);
    PS2_DAT = b;
    repeat (5) @(posedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (10) @(posedge CLOCK_50);
    PS2_CLK = 1'b1;
    repeat (5) @(posedge CLOCK_50);
  endtask

  // bad: 0 = good frame, 1 = parity flipped, 2 = stop bit low
  task automatic send_frame(input logic [7:0] b, input int bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ (bad == 1));
    ps2_bit(bad != 2);
    PS2_DAT = 1'b1;
    repeat (10) @(posedge CLOCK_50);
  endtask

  task automatic check_frame(input string name, input int exp_n, input int exp_code,
                             input int exp_err);
    checks++;
    if (ev_codes.size() != exp_n) begin
      errors++;
      $display("FAIL %s events: got %0d expected %0d", name, ev_codes.size(), exp_n);
    end else if (exp_n == 1) begin
      checks++;
      if (ev_codes[0] != exp_code) begin
        errors++;
        $display("FAIL %s code: got %0d expected %0d", name, ev_codes[0], exp_code);
      end
    end
    checks++;
    if (err_seen != exp_err) begin
      errors++;
      $display("FAIL %s rx_error: got %0d pulses expected %0d", name, err_seen, exp_err);
    end
    ev_codes.delete();
    err_seen = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge CLOCK_50);
    checks++;
    if (KEY_PRESSED !== 5'd31 || key_valid !== 1'b0 || rx_error !== 1'b0) begin
      errors++;
      $display("FAIL %s: got key=%0d valid=%b err=%b expected key=31 valid=0 err=0",
               name, KEY_PRESSED, key_valid, rx_error);
    end
  endtask

  typedef struct {
    logic [7:0] sc;
    int         bad;
    int         n;
    int         code;
    int         err;
  } vec_t;

  vec_t tab[15];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, code, err, sel, bad;
    logic [7:0] b;

    sc_tab = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
               8'h43, 8'h42, 8'h3B, 8'h4B, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29};
    for (int k = 0; k < 17; k++) ext_tab[k] = (k >= 4 && k <= 7);

    tab[0]  = '{8'h1D, 0, 1, 0,  0};
    tab[1]  = '{8'hE0, 0, 0, 31, 0};
    tab[2]  = '{8'h75, 0, 1, 4,  0};
    tab[3]  = '{8'h75, 0, 1, 12, 0};
    tab[4]  = '{8'hE0, 0, 0, 31, 0};
    tab[5]  = '{8'h1D, 0, 0, 31, 0};
    tab[6]  = '{8'hF0, 0, 0, 31, 0};
    tab[7]  = '{8'h1D, 0, 0, 31, 0};
    tab[8]  = '{8'h1B, 0, 1, 1,  0};
    tab[9]  = '{8'h29, 1, 0, 31, 1};
    tab[10] = '{8'h29, 0, 1, 16, 0};
    tab[11] = '{8'hE0, 0, 0, 31, 0};
    tab[12] = '{8'h6B, 2, 0, 31, 1};
    tab[13] = '{8'h6B, 0, 1, 14, 0};
    tab[14] = '{8'h29, 0, 1, 16, 0};

    reset   = 1'b1;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    repeat (5) @(posedge CLOCK_50);

    for (int i = 0; i < 15; i++) begin
      send_frame(tab[i].sc, tab[i].bad);
      check_frame($sformatf("vec%0d_%02h", i, tab[i].sc), tab[i].n, tab[i].code, tab[i].err);
    end
    m_ext = 0; m_brk = 0;

    // Partial frame abandoned: timeout must fire and return the receiver to idle
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    PS2_DAT = 1'b1;
    repeat (50010) @(posedge CLOCK_50);
    check_frame("timeout", 0, 31, 1);
    send_frame(8'h23, 0);
    check_frame("after_timeout_23", 1, 3, 0);

    // Reset in the middle of a frame following an E0 prefix
    send_frame(8'hE0, 0);
    check_frame("pre_reset_E0", 0, 31, 0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(posedge CLOCK_50);
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    check_reset_outputs("mid_frame_reset");
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    reset = 1'b0;
    ev_codes.delete();
    err_seen = 0;
    m_ext = 0; m_brk = 0;
    repeat (5) @(posedge CLOCK_50);
    send_frame(8'h74, 0);
    check_frame("after_reset_74", 1, 15, 0);

    // Random frames against the reference model
    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(0, 22);
      if (sel < 17)       b = sc_tab[sel];
      else if (sel < 19)  b = 8'hE0;
      else if (sel < 21)  b = 8'hF0;
      else                b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      model_byte(b, bad == 0, n, code, err);
      send_frame(b, bad);
      check_frame($sformatf("rand%0d_%02h", r, b), n, code, err);
    end

    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL idle_code: %0d cycles without key_valid where KEY_PRESSED was not 31", idle_bad);
    end
    checks++;
    if (multi_bad != 0) begin
      errors++;
      $display("FAIL pulse_width: key_valid high on %0d consecutive cycles, expected 0", multi_bad);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
